// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, FSM state encoding and register-map constants.
package apb_pkg;

  localparam int APB_DATA_W  = 32;
  localparam int APB_ADDR_W  = 32;
  localparam int APB_NSEL    = 3;
  localparam int WAITCFG_IDX = 0;
  localparam int WAIT_W      = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Word index of a register from the low byte-address bits kept by the slave.
  function automatic logic [3:0] reg_index(input logic [5:0] addr);
    return addr[5:2];
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter: loaded at the setup phase, counts down during the access phase.
module apb_wait_counter
  import apb_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         cnt_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a small 32-bit register bank and programmable wait states.
// reg0 is WAITCFG (4-bit wait count); the remaining registers are plain 32-bit RW.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int SLV_ID       = 0,
  parameter int NUM_REGS     = 8,
  parameter int WAIT_DEFAULT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [APB_NSEL-1:0]   Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

  logic                  sel;
  apb_state_e            state_q, state_d;
  logic [5:0]            addr_q, addr_d;
  logic                  write_q, write_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0]     wait_cfg_q;
  logic                  setup_fire;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic                  done;
  logic                  addr_err;
  logic                  commit;
  logic [3:0]            idx_q;
  logic [APB_DATA_W-1:0] rdata_sel;
  logic [APB_DATA_W-1:0] rd_word [NUM_REGS];
  logic                  unused_inputs;

  assign sel   = Pselx[SLV_ID];
  assign idx_q = reg_index(addr_q);

  // The bridge has already decoded the slot, so the upper address bits and the
  // other select lines carry no information for this slave.
  assign unused_inputs = ^{Paddr[APB_ADDR_W-1:6], Pselx};

  // Next-state and capture logic for the two-state APB protocol machine.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    setup_fire = 1'b0;
    cnt_dec    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && !Penable) begin
          setup_fire = 1'b1;
          addr_d     = Paddr[5:0];
          write_d    = Pwrite;
          wdata_d    = Pwdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (sel && Penable) begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          // Dropped select or enable mid-transfer: abandon without response.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle never completes a transfer, even if the counter hit zero.
    if (!rst) begin
      done = 1'b0;
    end
  end

  // Protocol state and setup-phase capture registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  apb_wait_counter #(
    .W(WAIT_W)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (setup_fire),
    .load_val(wait_cfg_q),
    .dec     (cnt_dec),
    .cnt_zero(cnt_zero)
  );

  assign addr_err = (addr_q[1:0] != 2'b00) || ({1'b0, idx_q} >= NUM_REGS_W);
  assign commit   = done && write_q && !addr_err;

  // Register bank: WAITCFG holds only its low nibble, the rest are full words.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    if (gi == WAITCFG_IDX) begin : g_waitcfg
      logic [WAIT_W-1:0] wait_cfg_d;

      // WAITCFG update; the new value is only seen by the next setup phase.
      always_comb begin
        wait_cfg_d = wait_cfg_q;
        if (commit && (idx_q == 4'(gi))) begin
          wait_cfg_d = wdata_q[WAIT_W-1:0];
        end
      end

      // WAITCFG storage, reset to the configured default wait count.
      always_ff @(posedge clk) begin
        if (!rst) begin
          wait_cfg_q <= WAIT_W'(WAIT_DEFAULT);
        end else begin
          wait_cfg_q <= wait_cfg_d;
        end
      end

      assign rd_word[gi] = {{(APB_DATA_W-WAIT_W){1'b0}}, wait_cfg_q};
    end else begin : g_data
      logic [APB_DATA_W-1:0] reg_q, reg_d;

      // General-purpose register update on a committed, error-free write.
      always_comb begin
        reg_d = reg_q;
        if (commit && (idx_q == 4'(gi))) begin
          reg_d = wdata_q;
        end
      end

      // General-purpose register storage.
      always_ff @(posedge clk) begin
        if (!rst) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rd_word[gi] = reg_q;
    end
  end

  // Read mux over the bank; out-of-range indices fall through to zero.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_q == 4'(i)) begin
        rdata_sel = rd_word[i];
      end
    end
  end

  assign Pready  = done;
  assign Pslverr = done && addr_err;
  assign Prdata  = (done && !write_q && !addr_err) ? rdata_sel : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: APB transfers checked against a scoreboard
// of expected responses built from a small register model.
module tb_apb_slave_regfile;

  localparam int          SLV_ID       = 1;
  localparam int          NUM_REGS     = 8;
  localparam int          WAIT_DEFAULT = 0;
  localparam logic [2:0]  SEL          = 3'b010;
  localparam int          CYC_BUDGET   = 32;

  logic        clk;
  logic        rst;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_reg [NUM_REGS];
  logic [3:0]  mdl_wait;
  int          n_checks;
  int          n_errors;

  apb_slave_regfile #(
    .SLV_ID      (SLV_ID),
    .NUM_REGS    (NUM_REGS),
    .WAIT_DEFAULT(WAIT_DEFAULT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Pselx  (Pselx),
    .Penable(Penable),
    .Pwrite (Pwrite),
    .Paddr  (Paddr),
    .Pwdata (Pwdata),
    .Prdata (Prdata),
    .Pready (Pready),
    .Pslverr(Pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NUM_REGS; i++) mdl_reg[i] = '0;
    mdl_wait = 4'(WAIT_DEFAULT);
  endtask

  // One complete APB transfer; the expected response is queued at setup.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
    exp_t       e;
    exp_t       got;
    logic [3:0] idx;
    logic       err;
    int         waits;
    bit         seen;
    idx     = addr[5:2];
    err     = (addr[1:0] != 2'b00) || (int'(idx) >= NUM_REGS);
    e.err   = err;
    e.waits = int'(mdl_wait);
    if (wr || err)    e.rdata = '0;
    else if (idx == 0) e.rdata = {28'b0, mdl_wait};
    else               e.rdata = mdl_reg[idx];
    sb_q.push_back(e);

    Pselx = SEL; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wdata;
    @(negedge clk);
    chk({tag, "_setup_rdy"}, {31'b0, Pready}, 32'd0);
    @(posedge clk); #1;
    Penable = 1'b1;
    Pwdata  = ~wdata;
    waits = 0;
    seen  = 1'b0;
    for (int c = 0; c < CYC_BUDGET && !seen; c++) begin
      @(negedge clk);
      if (Pready) begin
        seen = 1'b1;
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    got = sb_q.pop_front();
    if (!seen) begin
      chk({tag, "_timeout_rdy"}, {31'b0, Pready}, 32'd1);
    end else begin
      chk({tag, "_waits"}, 32'(waits), 32'(got.waits));
      chk({tag, "_slverr"}, {31'b0, Pslverr}, {31'b0, got.err});
      chk({tag, "_rdata"}, Prdata, got.rdata);
      $display("xfer %s wr=%0d addr=0x%08h waits=%0d slverr=%0d rdata=0x%08h",
               tag, wr, addr, waits, Pslverr, Prdata);
      if (wr && !err) begin
        if (idx == 0) mdl_wait = wdata[3:0];
        else          mdl_reg[idx] = wdata;
      end
      @(posedge clk); #1;
    end
    Pselx = 3'b000; Penable = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk(tag, {31'b0, Pready}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mdl_reset();
    rst = 1'b0; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_rdy", {31'b0, Pready}, 32'd0);
    chk("reset_err", {31'b0, Pslverr}, 32'd0);
    chk("reset_rdata", Prdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    $display("reset released");

    // Zero-wait write then read.
    apb_xfer(1'b1, 32'h08, 32'hDEADBEEF, "wr08");
    apb_xfer(1'b0, 32'h08, 32'h0, "rd08");

    // Wait states via WAITCFG; upper WAITCFG bits read back as zero.
    apb_xfer(1'b1, 32'h00, 32'hFFFF_FFF3, "wr_wait3");
    apb_xfer(1'b0, 32'h00, 32'h0, "rd_wait3");
    apb_xfer(1'b0, 32'h04, 32'h0, "rd04_w3");
    apb_xfer(1'b1, 32'h00, 32'h0, "wr_wait0");

    // Misaligned write is rejected; reg2 keeps its value.
    apb_xfer(1'b1, 32'h0A, 32'h1234_5678, "wr_misal");
    apb_xfer(1'b0, 32'h08, 32'h0, "rd08_after_err");

    // Out-of-range read; upper address bits ignored on a valid access.
    apb_xfer(1'b0, 32'h20, 32'h0, "rd_oor");
    apb_xfer(1'b1, 32'hFFFF_FF0C, 32'hCAFE_0001, "wr0c_hi");
    apb_xfer(1'b0, 32'h0C, 32'h0, "rd0c");

    // Not selected: wrong select line for a full setup/access sequence.
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h08; Pwdata = 32'h5555_AAAA;
    idle_check("nosel_setup_rdy", 1);
    Penable = 1'b1;
    idle_check("nosel_access_rdy", 3);
    Pselx = 3'b000; Penable = 1'b0;
    apb_xfer(1'b0, 32'h08, 32'h0, "rd08_nosel");

    // Abort mid-wait: WAITCFG=5, drop the select after two wait cycles.
    apb_xfer(1'b1, 32'h00, 32'h5, "wr_wait5");
    Pselx = SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h0C; Pwdata = 32'hBAD0_BAD0;
    idle_check("abort_setup_rdy", 1);
    Penable = 1'b1;
    idle_check("abort_wait_rdy", 2);
    Pselx = 3'b000;
    idle_check("abort_drop_rdy", 1);
    Penable = 1'b0;
    idle_check("abort_idle_rdy", 3);
    apb_xfer(1'b0, 32'h0C, 32'h0, "rd0c_abort");

    // Reset during a transfer, on the cycle it would otherwise complete.
    apb_xfer(1'b1, 32'h04, 32'h0000_0011, "wr04_pre");
    apb_xfer(1'b1, 32'h00, 32'h1, "wr_wait1");
    Pselx = SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'h7777_7777;
    idle_check("rstx_setup_rdy", 1);
    Penable = 1'b1;
    idle_check("rstx_wait_rdy", 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstx_rst_rdy", {31'b0, Pready}, 32'd0);
    chk("rstx_rst_err", {31'b0, Pslverr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; Pselx = 3'b000; Penable = 1'b0;
    mdl_reset();
    $display("mid-transfer reset applied");
    for (int i = 0; i < NUM_REGS; i++) begin
      apb_xfer(1'b0, 32'(i * 4), 32'h0, $sformatf("rd_after_rst%0d", i));
    end

    // Back-to-back writes with no gap, then read both back.
    apb_xfer(1'b1, 32'h04, 32'h0BAD_F00D, "b2b_wr04");
    apb_xfer(1'b1, 32'h0C, 32'h1357_9BDF, "b2b_wr0c");
    apb_xfer(1'b0, 32'h04, 32'h0, "b2b_rd04");
    apb_xfer(1'b0, 32'h0C, 32'h0, "b2b_rd0c");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (slave) at the far end of the AHB-to-APB bridge.
- Decodes one bit of the bridge's 3-bit Pselx and services single APB read/write transfers into a small 32-bit register bank.
- Inserts a programmable number of wait states via Pready and flags bad accesses with Pslverr.
- One instance per peripheral slot; it is the bench target for bridge-level integration.

Parameters:
- SLV_ID, 0, which Pselx bit selects this slave (0..2)
- NUM_REGS, 8, number of 32-bit registers (power of 2, 2..16); index = Paddr[5:2]
- WAIT_DEFAULT, 0, reset value of the wait-state field (0..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- Pselx  in  3  slave selects from bridge; this slave uses Pselx[SLV_ID]
- Penable  in  1  APB access phase
- Pwrite  in  1  1=write, 0=read
- Paddr  in  32  byte address
- Pwdata  in  32  write data
- Prdata  out  32  read data, valid only while Pready=1 and Pwrite latched 0; else 0
- Pready  out  1  transfer completes this cycle
- Pslverr  out  1  error response, valid only with Pready=1; else 0

Behaviour:
- Reset: rst is synchronous and active-low on clock clk.
  - All registers clear to 0, except reg0[3:0] = WAIT_DEFAULT.
  - State = IDLE, wait counter = 0.
  - Pready = 0, Pslverr = 0, Prdata = 0.
  - Reset mid-transfer aborts it; no write commits.
- Register map:
  - reg0 = WAITCFG: bits[3:0] RW, bits[31:4] read 0, writes ignored.
  - reg1..reg(NUM_REGS-1): full 32-bit RW.
- sel = Pselx[SLV_ID].
- FSM states: IDLE, ACCESS.
- IDLE:
  - On sel=1 and Penable=0 (setup phase), capture in the same cycle: addr_q=Paddr, write_q=Pwrite, wdata_q=Pwdata, cnt=WAITCFG[3:0]. Next state is ACCESS.
  - Otherwise stay in IDLE.
  - Pready=0 throughout IDLE.
- ACCESS, with sel=1 and Penable=1:
  - cnt != 0: Pready=0, cnt decrements, stay in ACCESS.
  - cnt == 0: Pready=1 combinationally in that cycle. At that clock edge a write commits (if no error) and the state returns to IDLE.
- ACCESS, with sel=0 or Penable=0 (protocol violation or abort): return to IDLE, no commit, no Pready.
- Latency: zero-wait transfer = 2 cycles (setup, access); N wait states = 2+N cycles.
- Back-to-back transfers: a setup arriving in the cycle after Pready is accepted from IDLE with no gap cycle.
- Error: Pslverr=1 together with Pready=1 when addr_q[1:0] != 0 or addr_q index >= NUM_REGS.
  - Error writes are dropped.
  - Error reads return Prdata=0.
- Read data: Prdata = register[addr_q index], muxed combinationally during the Pready cycle.
- Write to WAITCFG: takes effect from the next setup phase; it does not change the current counter.
- Address bits above the index, [31:6], are ignored; the bridge has already decoded the slot.
- Pwdata is sampled only at setup; later changes are ignored.

Decomposition:
- Shared package apb_pkg holds:
  - state encoding: IDLE=1'b0, ACCESS=1'b1
  - APB_DATA_W=32, APB_ADDR_W=32, APB_NSEL=3
  - WAITCFG_IDX=0, WAIT_W=4
- One sub-module: apb_wait_counter (load, decrement, zero flag). The register bank stays inline.

Test Plan:
- Zero-wait write then read, SLV_ID=1:
  - Stimulus: Pselx=3'b010, Paddr=0x08, Pwdata=0xDEADBEEF.
  - Required: Pready high in cycle 2; following read of 0x08 returns Prdata=0xDEADBEEF, Pslverr=0.
- Wait states:
  - Stimulus: write WAITCFG=3, then read 0x04.
  - Required: Pready low for 3 access cycles and high in the 4th (5 cycles total); Prdata=0.
- Error, misaligned:
  - Stimulus: write Paddr=0x0A.
  - Required: Pready=1 and Pslverr=1 in cycle 2; reg2 unchanged.
- Error, out of range:
  - Stimulus: read Paddr=0x20 with NUM_REGS=8.
  - Required: Pslverr=1, Prdata=0.
- Not selected:
  - Stimulus: Pselx=3'b001 with SLV_ID=1.
  - Required: no Pready, no register change.
- Abort and reset:
  - Stimulus: WAITCFG=5; drop Pselx mid-wait; then rst=0 for one cycle during a later transfer.
  - Required: abort returns to IDLE, Pready never asserted, no write. Reset forces Pready=0, reg1..7=0, WAITCFG=WAIT_DEFAULT. Back-to-back writes to 0x04 and 0x0C are both committed.
